// File: rtl/lsu_controller_pkg.sv
// Shared size codes, FSM state encoding and byte-lane helpers for the load/store unit.
package lsu_controller_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    function automatic logic size_is_bad(input logic [2:0] size);
        size_is_bad = (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
    endfunction

    // Low address bits the access actually uses: halfwords ignore bit 0, words ignore both.
    function automatic logic [1:0] eff_off(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: eff_off = off;
            LDST_H, LDST_HU: eff_off = {off[1], 1'b0};
            default:         eff_off = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] be_for(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: be_for = 4'b0001 << off;
            LDST_H, LDST_HU: be_for = 4'b0011 << off;
            default:         be_for = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_for(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            LDST_B, LDST_BU: wdata_for = {4{wd[7:0]}};
            LDST_H, LDST_HU: wdata_for = {2{wd[15:0]}};
            default:         wdata_for = wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// Data memory bus between the LSU (master) and the memory (slave).
interface lsu_controller_if;
    // Handshake: data_req_o is held with stable we/be/addr/wdata until the cycle data_gnt_i=1;
    // exactly one data_rvalid_i follows in a later cycle for every granted request.
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/lsu_controller_load_ext.sv
// Combinational load alignment: picks the byte/halfword by offset and sign- or zero-extends it.
module lsu_load_ext
    import lsu_controller_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_data = {24'h0, w_byte};
            LDST_H:  o_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: runs one req/gnt/rvalid bus access per core request and stalls the core meanwhile.
// Optional build macro MISALIGN_TRAP_EN turns misaligned halfword/word accesses into an error pulse.
module lsu_controller
    import lsu_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          lsu_req_i,
    input  logic          lsu_we_i,
    input  logic [2:0]    lsu_size_i,
    input  logic [31:0]   lsu_addr_i,
    input  logic [31:0]   lsu_wdata_i,
    output logic [31:0]   lsu_rdata_o,
    output logic          lsu_stall_o,
    output logic          lsu_err_o,
    output logic [2:0]    lsu_state_o,
    lsu_controller_if.master bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  r_state, w_state_nxt;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  w_off;
    logic [31:0] w_ext;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_in_req;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (((lsu_size_i == LDST_H) || (lsu_size_i == LDST_HU)) && lsu_addr_i[0]) ||
                        ((lsu_size_i == LDST_W) && (lsu_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_off     = eff_off(r_size, r_addr[1:0]);
    assign w_timeout = (r_cnt == TO_LAST);
    assign w_in_req  = (r_state == ST_REQ);

    lsu_load_ext u_load_ext (
        .i_rdata (bus.data_rdata_i),
        .i_size  (r_size),
        .i_off   (w_off),
        .o_data  (w_ext)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        lsu_stall_o = 1'b0;
        lsu_err_o   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                lsu_stall_o = lsu_req_i & reset_i;
                if (lsu_req_i)
                    w_state_nxt = (size_is_bad(lsu_size_i) || w_misalign) ? ST_ERR : ST_REQ;
            end
            ST_REQ: begin
                lsu_stall_o = 1'b1;
                if (bus.data_gnt_i)  w_state_nxt = ST_RESP;
                else if (w_timeout)  w_state_nxt = ST_ERR;
            end
            ST_RESP: begin
                lsu_stall_o = 1'b1;
                if (bus.data_rvalid_i) w_state_nxt = ST_DONE;
                else if (w_timeout)    w_state_nxt = ST_ERR;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR: begin
                lsu_err_o   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter spans REQ and RESP together; it is zero whenever an access enters REQ.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)                                       r_cnt <= 8'd0;
        else if ((r_state == ST_REQ) || (r_state == ST_RESP)) r_cnt <= r_cnt + 8'd1;
        else                                                r_cnt <= 8'd0;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_we    <= 1'b0;
            r_size  <= LDST_B;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if ((r_state == ST_IDLE) && lsu_req_i) begin
            r_we    <= lsu_we_i;
            r_size  <= lsu_size_i;
            r_addr  <= lsu_addr_i;
            r_wdata <= lsu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)                                   r_rdata <= 32'h0;
        else if ((r_state == ST_RESP) && bus.data_rvalid_i) r_rdata <= w_ext;
    end

    assign lsu_rdata_o      = r_rdata;
    assign lsu_state_o      = r_state;
    assign bus.data_req_o   = w_in_req;
    assign bus.data_we_o    = w_in_req & r_we;
    assign bus.data_be_o    = w_in_req ? be_for(r_size, w_off) : 4'h0;
    assign bus.data_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus.data_wdata_o = w_in_req ? wdata_for(r_size, r_wdata) : 32'h0;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed self-checking bench for lsu_controller with hand-computed expectations.
module tb_lsu_controller;
    import lsu_controller_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_stall_o, lsu_err_o;
    logic [2:0]  lsu_state_o;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];

    lsu_controller_if bus_if ();

    lsu_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .lsu_req_i   (lsu_req_i),
        .lsu_we_i    (lsu_we_i),
        .lsu_size_i  (lsu_size_i),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .lsu_rdata_o (lsu_rdata_o),
        .lsu_stall_o (lsu_stall_o),
        .lsu_err_o   (lsu_err_o),
        .lsu_state_o (lsu_state_o),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_size_i  = size;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
    endtask

    // One access with immediate gnt and rvalid; checks every stage along the way.
    task automatic run_access(input string tag, input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] bus_rdata,
                              input logic [3:0] exp_be, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        if (!we) exp_q.push_back(exp_rdata);
        @(negedge clk);
        set_req(we, size, addr, 32'h1234ABCD);
        #1;
        check({tag, ".idle_stall"}, lsu_stall_o, 1'b1);
        @(negedge clk);
        check({tag, ".req"}, bus_if.data_req_o, 1'b1);
        check({tag, ".req_stall"}, lsu_stall_o, 1'b1);
        check({tag, ".be"}, bus_if.data_be_o, exp_be);
        check({tag, ".addr"}, bus_if.data_addr_o, exp_addr);
        check({tag, ".we"}, bus_if.data_we_o, we);
        check({tag, ".wdata"}, bus_if.data_wdata_o, exp_wdata);
        bus_if.data_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.data_gnt_i = 1'b0;
        check({tag, ".resp_req"}, bus_if.data_req_o, 1'b0);
        check({tag, ".resp_stall"}, lsu_stall_o, 1'b1);
        bus_if.data_rvalid_i = 1'b1;
        bus_if.data_rdata_i  = bus_rdata;
        @(negedge clk);
        bus_if.data_rvalid_i = 1'b0;
        check({tag, ".done_state"}, lsu_state_o, ST_DONE);
        check({tag, ".done_stall"}, lsu_stall_o, 1'b0);
        check({tag, ".done_err"}, lsu_err_o, 1'b0);
        if (!we) check({tag, ".rdata"}, lsu_rdata_o, exp_q.pop_front());
        lsu_req_i = 1'b0;
    endtask

    // Request that must be rejected straight from IDLE with no bus activity.
    task automatic run_reject(input string tag, input logic [2:0] size, input logic [31:0] addr);
        @(negedge clk);
        set_req(1'b0, size, addr, 32'h0);
        #1;
        check({tag, ".stall"}, lsu_stall_o, 1'b1);
        @(negedge clk);
        check({tag, ".err"}, lsu_err_o, 1'b1);
        check({tag, ".err_state"}, lsu_state_o, ST_ERR);
        check({tag, ".err_stall"}, lsu_stall_o, 1'b0);
        check({tag, ".no_req"}, bus_if.data_req_o, 1'b0);
        lsu_req_i = 1'b0;
        @(negedge clk);
        check({tag, ".idle"}, lsu_state_o, ST_IDLE);
        check({tag, ".err_gone"}, lsu_err_o, 1'b0);
        check({tag, ".still_no_req"}, bus_if.data_req_o, 1'b0);
    endtask

    initial begin
        reset_i = 1'b0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = LDST_W;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        bus_if.data_gnt_i = 1'b0; bus_if.data_rvalid_i = 1'b0; bus_if.data_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.state", lsu_state_o, ST_IDLE);
        check("rst.stall", lsu_stall_o, 1'b0);
        check("rst.err", lsu_err_o, 1'b0);
        check("rst.rdata", lsu_rdata_o, 32'h0);
        check("rst.req", bus_if.data_req_o, 1'b0);
        check("rst.be", bus_if.data_be_o, 4'h0);
        reset_i = 1'b1;

        // Word load, then sub-word loads of the same bus word.
        run_access("ldw",  1'b0, LDST_W,  32'h100, 32'hDEADBEEF, 4'hF, 32'h100, 32'h1234ABCD, 32'hDEADBEEF);
        @(negedge clk);
        check("ldw.hold", lsu_rdata_o, 32'hDEADBEEF);
        run_access("ldb",  1'b0, LDST_B,  32'h103, 32'h80FF7F01, 4'b1000, 32'h100, 32'hCDCDCDCD, 32'hFFFFFF80);
        run_access("ldbu", 1'b0, LDST_BU, 32'h103, 32'h80FF7F01, 4'b1000, 32'h100, 32'hCDCDCDCD, 32'h00000080);
        run_access("ldh",  1'b0, LDST_H,  32'h102, 32'h80FF7F01, 4'b1100, 32'h100, 32'hABCDABCD, 32'hFFFF80FF);
        run_access("ldhu", 1'b0, LDST_HU, 32'h100, 32'h80FF7F01, 4'b0011, 32'h100, 32'hABCDABCD, 32'h00007F01);
        run_access("ldb1", 1'b0, LDST_B,  32'h101, 32'h80FF7F01, 4'b0010, 32'h100, 32'hCDCDCDCD, 32'h0000007F);

        // Stores.
        run_access("sth", 1'b1, LDST_H, 32'h102, 32'h0, 4'b1100, 32'h100, 32'hABCDABCD, 32'h0);
        run_access("stb", 1'b1, LDST_B, 32'h201, 32'h0, 4'b0010, 32'h200, 32'hCDCDCDCD, 32'h0);

        // Grant withheld: error one cycle after the counter reaches TO-1.
        @(negedge clk);
        set_req(1'b0, LDST_W, 32'h400, 32'h0);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to.req_state", lsu_state_o, ST_REQ);
            check("to.no_err", lsu_err_o, 1'b0);
        end
        @(negedge clk);
        check("to.err", lsu_err_o, 1'b1);
        check("to.err_stall", lsu_stall_o, 1'b0);
        check("to.err_req", bus_if.data_req_o, 1'b0);
        lsu_req_i = 1'b0;
        @(negedge clk);
        check("to.idle", lsu_state_o, ST_IDLE);
        bus_if.data_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.data_gnt_i = 1'b0;
        check("to.late_gnt_state", lsu_state_o, ST_IDLE);
        check("to.late_gnt_err", lsu_err_o, 1'b0);

        // Misaligned word.
`ifdef MISALIGN_TRAP_EN
        run_reject("mis", LDST_W, 32'h101);
`else
        run_access("mis", 1'b0, LDST_W, 32'h101, 32'h55AA33CC, 4'hF, 32'h100, 32'h1234ABCD, 32'h55AA33CC);
`endif

        // Reset in RESP, then a stray rvalid after release.
        @(negedge clk);
        set_req(1'b0, LDST_W, 32'h300, 32'h0);
        @(negedge clk);
        bus_if.data_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.data_gnt_i = 1'b0;
        check("rr.resp", lsu_state_o, ST_RESP);
        reset_i = 1'b0;
        lsu_req_i = 1'b0;
        #1;
        check("rr.state", lsu_state_o, ST_IDLE);
        check("rr.stall", lsu_stall_o, 1'b0);
        check("rr.rdata", lsu_rdata_o, 32'h0);
        check("rr.req", bus_if.data_req_o, 1'b0);
        check("rr.addr", bus_if.data_addr_o, 32'h0);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        bus_if.data_rvalid_i = 1'b1;
        bus_if.data_rdata_i  = 32'hCAFEF00D;
        @(negedge clk);
        bus_if.data_rvalid_i = 1'b0;
        check("rr.late_state", lsu_state_o, ST_IDLE);
        check("rr.late_rdata", lsu_rdata_o, 32'h0);
        @(negedge clk);
        check("rr.late_rdata2", lsu_rdata_o, 32'h0);

        // Bad size code.
        run_reject("bad3", 3'd3, 32'h100);
        run_reject("bad7", 3'd7, 32'h100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
